// File: rtl/trng_sampler.sv
// trng_sampler: synchronizes ring-oscillator outputs, XOR-folds them to one raw bit
// per sample tick, optionally von Neumann debiases, and packs bits into words.
// Ports: clk/rst_n (async active-low), raw_in async ring outputs, en sampling enable,
// vn_bypass skip debiasing, sample_div tick period-1, rnd_data/rnd_valid/rnd_ready
// one-deep output handshake, drop_cnt saturating count of backpressure losses,
// health_fail sticky repetition-count failure.
module trng_sampler #(
  parameter int N_RINGS     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DIV_WIDTH   = 8,
  parameter int OUT_WIDTH   = 8,
  parameter int REP_LIMIT   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_RINGS-1:0]   raw_in,
  input  logic                 en,
  input  logic                 vn_bypass,
  input  logic [DIV_WIDTH-1:0] sample_div,
  output logic [OUT_WIDTH-1:0] rnd_data,
  output logic                 rnd_valid,
  input  logic                 rnd_ready,
  output logic [7:0]           drop_cnt,
  output logic                 health_fail
);
  localparam int BW = OUT_WIDTH > 1 ? $clog2(OUT_WIDTH) : 1;
  localparam int RW = $clog2(REP_LIMIT + 1);
  typedef enum logic {FIRST, SECOND} state_t;
  logic [N_RINGS-1:0]   sync_q [SYNC_STAGES];
  logic [DIV_WIDTH-1:0] div_q;
  state_t               state_q, state_d;
  logic                 first_q;
  logic [OUT_WIDTH-1:0] shreg;
  logic [BW-1:0]        bcnt;
  logic [RW-1:0]        rep_q;
  logic                 last_q;
  logic                 b, tick, emit, ebit, last_bit, done, same, load, drop;
  logic [OUT_WIDTH-1:0] word;
  assign b    = ^sync_q[SYNC_STAGES-1];
  assign tick = en && div_q == '0;
  assign same = b == last_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '{default: '0};
    end else begin
      sync_q[0] <= raw_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  // Counter preloads sample_div while disabled so the first tick after enable
  // lands sample_div+1 clocks later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= (!en || tick) ? sample_div : div_q - 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FIRST;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = !tick ? state_q : (vn_bypass || state_q == SECOND) ? FIRST : SECOND;
  end
  always_comb begin
    emit = tick && (vn_bypass || (state_q == SECOND && first_q != b));
    ebit = vn_bypass ? b : first_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                     first_q <= 1'b0;
    else if (tick && state_q == FIRST && !vn_bypass) first_q <= b;
  end
  assign last_bit = bcnt == BW'(OUT_WIDTH - 1);
  assign done     = emit && last_bit;
  assign word     = {ebit, shreg[OUT_WIDTH-1:1]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      bcnt  <= '0;
    end else if (emit) begin
      shreg <= word;
      bcnt  <= last_bit ? '0 : bcnt + 1'b1;
    end
  end
  // A failed health test silently discards words; only backpressure counts as a drop.
  assign load = done && !health_fail && (!rnd_valid || rnd_ready);
  assign drop = done && !health_fail && rnd_valid && !rnd_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_data  <= '0;
      rnd_valid <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (load) rnd_data <= word;
      rnd_valid <= load || (rnd_valid && !rnd_ready);
      drop_cnt  <= drop_cnt + {7'b0, drop && drop_cnt != 8'hFF};
    end
  end
  // Run length saturates at REP_LIMIT so it cannot wrap after a failure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q       <= '0;
      last_q      <= 1'b0;
      health_fail <= 1'b0;
    end else if (tick) begin
      last_q      <= b;
      rep_q       <= !same ? RW'(1) : rep_q == RW'(REP_LIMIT) ? rep_q : rep_q + 1'b1;
      health_fail <= health_fail || (same && rep_q == RW'(REP_LIMIT - 1));
    end
  end
endmodule

// File: tb/tb_trng_sampler.sv
// tb_trng_sampler: randomized and directed stimulus checked every cycle against a behavioural model.
module tb_trng_sampler;
  logic       clk = 0, rst_n = 0, en = 0, vn_bypass = 0, rnd_ready = 0;
  logic [7:0] raw_in = 0, sample_div = 0;
  logic [7:0] rnd_data, drop_cnt;
  logic       rnd_valid, health_fail;
  int checks = 0, errors = 0, vcount = 0, v0;

  trng_sampler dut (
    .clk(clk), .rst_n(rst_n), .raw_in(raw_in), .en(en), .vn_bypass(vn_bypass),
    .sample_div(sample_div), .rnd_data(rnd_data), .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready), .drop_cnt(drop_cnt), .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  // Model: raw bit is the parity of raw_in two clocks ago; pairs, bit queue and
  // one-deep output slot follow the behavioural rules directly.
  bit       m_s1, m_s2, m_last, m_fail, m_have, m_first, m_valid;
  int       m_dcnt, m_run, m_drop;
  bit [7:0] m_data;
  bit       m_bits[$];

  initial forever begin
    bit b, tick, emit, ebit, done, fail_old, acc;
    bit [7:0] w;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_last = 0; m_fail = 0; m_have = 0; m_first = 0;
      m_valid = 0; m_dcnt = 0; m_run = 0; m_drop = 0; m_data = 0; m_bits.delete();
    end else begin
      b = m_s2; m_s2 = m_s1; m_s1 = ^raw_in;
      tick = 0; emit = 0; ebit = 0; done = 0; w = 0;
      fail_old = m_fail; acc = m_valid && rnd_ready;
      if (!en) m_dcnt = sample_div;
      else if (m_dcnt == 0) begin tick = 1; m_dcnt = sample_div; end
      else m_dcnt--;
      if (tick) begin
        m_run = (b == m_last) ? m_run + 1 : 1;
        m_last = b;
        if (m_run >= 32) m_fail = 1;
        if (vn_bypass) begin emit = 1; ebit = b; m_have = 0; end
        else if (!m_have) begin m_first = b; m_have = 1; end
        else begin
          if (m_first != b) begin emit = 1; ebit = m_first; end
          m_have = 0;
        end
      end
      if (emit) begin
        m_bits.push_back(ebit);
        if (m_bits.size() == 8) begin
          for (int i = 0; i < 8; i++) w[i] = m_bits[i];
          m_bits.delete();
          done = 1;
        end
      end
      if (done && !fail_old) begin
        if (!m_valid || rnd_ready) begin m_data = w; m_valid = 1; end
        else if (m_drop < 255) m_drop++;
      end else if (acc) m_valid = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    chk("rnd_valid", {31'b0, rnd_valid}, {31'b0, m_valid});
    chk("rnd_data", {24'b0, rnd_data}, {24'b0, m_data});
    chk("drop_cnt", {24'b0, drop_cnt}, m_drop);
    chk("health_fail", {31'b0, health_fail}, {31'b0, m_fail});
    if (rnd_valid) vcount++;
  end

  function automatic logic [7:0] mk(input logic x);
    logic [7:0] r;
    r = 8'($urandom);
    r[0] = r[0] ^ (^r) ^ x;
    return r;
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  // Bit i of bits becomes the raw bit of the i-th tick; sample_div must be 0.
  task automatic feed(input logic [63:0] bits, input int n, input bit ready_last);
    for (int i = 0; i < n + 2; i++) begin
      raw_in = (i < n) ? mk(bits[i[5:0]]) : 8'($urandom);
      en = i >= 2;
      if (ready_last && i == n + 1) rnd_ready = 1;
      @(posedge clk); #2;
    end
    en = 0;
  endtask

  initial begin
    cyc(3);
    chk("reset_valid", {31'b0, rnd_valid}, 0);
    chk("reset_data", {24'b0, rnd_data}, 0);
    chk("reset_drop", {24'b0, drop_cnt}, 0);
    rst_n = 1;
    cyc(1);
    vn_bypass = 1; rnd_ready = 1; v0 = vcount;
    feed(64'h4D, 8, 0);
    cyc(3);
    chk("bypass_data", {24'b0, rnd_data}, 8'h4D);
    chk("bypass_valid_cycles", vcount - v0, 1);
    vn_bypass = 0; v0 = vcount;
    feed(64'hD2D2D2D2D2D2D2D2, 64, 0);
    cyc(3);
    chk("vn_data", {24'b0, rnd_data}, 8'hAA);
    chk("vn_words", vcount - v0, 2);
    vn_bypass = 1; rnd_ready = 0;
    feed(64'h963C, 16, 0);
    cyc(2);
    chk("bp_held_data", {24'b0, rnd_data}, 8'h3C);
    chk("bp_drop", {24'b0, drop_cnt}, 1);
    feed(64'h5A, 8, 1);
    rnd_ready = 0;
    chk("bp_third_valid", {31'b0, rnd_valid}, 1);
    chk("bp_third_data", {24'b0, rnd_data}, 8'h5A);
    chk("bp_third_drop", {24'b0, drop_cnt}, 1);
    rnd_ready = 1;
    cyc(2);
    feed(64'h7FFFFFFF, 31, 0);
    feed(64'h0, 1, 0);
    chk("health_31_then_0", {31'b0, health_fail}, 0);
    feed(64'h7FFFFFFF, 31, 0);
    chk("health_31", {31'b0, health_fail}, 0);
    feed(64'h1, 1, 0);
    chk("health_32", {31'b0, health_fail}, 1);
    cyc(2);
    rnd_ready = 0; v0 = vcount;
    feed({$urandom, $urandom}, 24, 0);
    cyc(2);
    chk("health_drop_held", {24'b0, drop_cnt}, 1);
    chk("health_no_word", vcount - v0, 0);
    rst_n = 0; cyc(1); rst_n = 1;
    sample_div = 3; vn_bypass = 1; rnd_ready = 0; en = 1;
    for (int i = 0; i < 28; i++) begin raw_in = 8'($urandom); cyc(1); end
    en = 0;
    chk("div_7_ticks", {31'b0, rnd_valid}, 0);
    for (int i = 0; i < 20; i++) begin raw_in = 8'($urandom); cyc(1); end
    chk("en_low_hold", {31'b0, rnd_valid}, 0);
    en = 1;
    cyc(3);
    chk("resume_3_clocks", {31'b0, rnd_valid}, 0);
    cyc(1);
    chk("resume_4_clocks", {31'b0, rnd_valid}, 1);
    en = 0; sample_div = 0;
    feed({$urandom, $urandom}, 16, 0);
    feed(64'h15, 5, 0);
    #1 rst_n = 0;
    #1;
    chk("midreset_valid", {31'b0, rnd_valid}, 0);
    chk("midreset_data", {24'b0, rnd_data}, 0);
    chk("midreset_drop", {24'b0, drop_cnt}, 0);
    #5 rst_n = 1;
    @(posedge clk); #2;
    rnd_ready = 1;
    feed(64'hC3, 8, 0);
    cyc(2);
    chk("post_reset_word", {24'b0, rnd_data}, 8'hC3);
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        sample_div = 8'($urandom_range(0, 3));
        vn_bypass = 1'($urandom);
      end
      raw_in = (i >= 2400 && i < 2600) ? mk(1'b1) : 8'($urandom);
      en = $urandom_range(0, 9) != 0;
      rnd_ready = 1'($urandom);
      cyc(1);
    end
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
